// File: rtl/alu_share_arbiter.sv
// Shares one edge-triggered ALU between two requesters: arbitrates, latches operands, pulses alu_enable,
// and returns result/zero to the owner. Optional macro ALU_CMD_CHECK_EN: illegal commands bypass the ALU.
module alu_share_arbiter #(
  parameter int DATA_W     = 32,
  parameter int CMD_W      = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  output logic              alu_enable,
  output logic [CMD_W-1:0]  alu_command,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FIRE,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [DATA_W-1:0] ILLEGAL_RESULT = DATA_W'(32'h1111_1111);

  state_t                       r_state;
  state_t                       w_state_next;
  logic                         r_last_grant;
  logic                         r_owner;
  logic                         r_alu_enable;
  logic [CMD_W-1:0]             r_cmd;
  logic [DATA_W-1:0]            r_data1;
  logic [DATA_W-1:0]            r_data2;
  logic [1:0]                   r_rsp_valid;
  logic [1:0][DATA_W-1:0]       r_rsp_result;
  logic [1:0]                   r_rsp_zero;

  logic                         w_any_valid;
  logic                         w_grant;
  logic                         w_accept;
  logic                         w_rsp_hs;
  logic                         w_bypass;
  logic [CMD_W-1:0]             w_sel_cmd;
  logic [DATA_W-1:0]            w_sel_a;
  logic [DATA_W-1:0]            w_sel_b;

  // Arbitration: on contention round-robin favours the port that did not win last time.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
    end else begin
      w_grant = req1_valid;
    end
    w_accept  = (r_state == S_IDLE) && w_any_valid;
    w_rsp_hs  = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    w_sel_cmd = w_grant ? req1_cmd : req0_cmd;
    w_sel_a   = w_grant ? req1_a   : req0_a;
    w_sel_b   = w_grant ? req1_b   : req0_b;
  end

`ifdef ALU_CMD_CHECK_EN
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(5'b00001);
  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(5'b00010);
  localparam logic [CMD_W-1:0] CMD_SL  = CMD_W'(5'b00100);
  localparam logic [CMD_W-1:0] CMD_XOR = CMD_W'(5'b01000);
  localparam logic [CMD_W-1:0] CMD_OR  = CMD_W'(5'b10000);
  localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(5'b00111);

  always_comb begin
    w_bypass = 1'b1;
    case (w_sel_cmd)
      CMD_SUB, CMD_ADD, CMD_SL, CMD_XOR, CMD_OR, CMD_AND: w_bypass = 1'b0;
      default: ;
    endcase
  end
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = w_bypass ? S_RESP : S_SETUP;
      S_SETUP:   w_state_next = S_FIRE;
      S_FIRE:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_RESP;
      S_RESP:    if (w_rsp_hs) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_enable <= 1'b0;
      r_cmd        <= '0;
      r_data1      <= '0;
      r_data2      <= '0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values regardless of order.
      r_state      <= w_state_next;
      r_alu_enable <= (w_state_next == S_FIRE);
      if (w_accept) begin
        r_cmd   <= w_sel_cmd;
        r_data1 <= w_sel_a;
        r_data2 <= w_sel_b;
        r_owner <= w_grant;
      end
      if (w_rsp_hs) r_last_grant <= r_owner;
    end
  end

  // Per-port response registers; the non-owner's copy stays cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these few response flops are reset because they drive outputs that must read 0.
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= '0;
    end else if (w_accept && w_bypass) begin
      r_rsp_valid[w_grant]  <= 1'b1;
      r_rsp_result[w_grant] <= ILLEGAL_RESULT;
      r_rsp_zero[w_grant]   <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_rsp_valid[r_owner]  <= 1'b1;
      r_rsp_result[r_owner] <= alu_result;
      r_rsp_zero[r_owner]   <= alu_zero;
    end else if (w_rsp_hs) begin
      r_rsp_valid[r_owner]  <= 1'b0;
      r_rsp_result[r_owner] <= '0;
      r_rsp_zero[r_owner]   <= 1'b0;
    end
  end

`ifdef ALU_CMD_CHECK_EN
  logic [1:0] r_rsp_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_err <= '0;
    end else if (w_accept && w_bypass) begin
      r_rsp_err[w_grant] <= 1'b1;
    end else if (w_rsp_hs) begin
      r_rsp_err[r_owner] <= 1'b0;
    end
  end

  assign rsp0_err = r_rsp_err[0];
  assign rsp1_err = r_rsp_err[1];
`else
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  assign req0_ready  = w_accept && (w_grant == 1'b0);
  assign req1_ready  = w_accept && (w_grant == 1'b1);
  assign rsp0_valid  = r_rsp_valid[0];
  assign rsp1_valid  = r_rsp_valid[1];
  assign rsp0_result = r_rsp_result[0];
  assign rsp1_result = r_rsp_result[1];
  assign rsp0_zero   = r_rsp_zero[0];
  assign rsp1_zero   = r_rsp_zero[1];
  assign alu_enable  = r_alu_enable;
  assign alu_command = r_cmd;
  assign alu_data1   = r_data1;
  assign alu_data2   = r_data2;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests push expected responses, a monitor pops and compares.
module tb_alu_share_arbiter;

  localparam logic [4:0] C_SUB = 5'b00001;
  localparam logic [4:0] C_ADD = 5'b00010;
  localparam logic [4:0] C_SL  = 5'b00100;
  localparam logic [4:0] C_XOR = 5'b01000;
  localparam logic [4:0] C_OR  = 5'b10000;
  localparam logic [4:0] C_AND = 5'b00111;
  localparam logic [4:0] C_BAD = 5'b00011;

`ifdef ALU_CMD_CHECK_EN
  localparam logic BAD_ERR    = 1'b1;
  localparam int   BAD_LAT    = 0;
  localparam int   BAD_PULSES = 0;
`else
  localparam logic BAD_ERR    = 1'b0;
  localparam int   BAD_LAT    = 3;
  localparam int   BAD_PULSES = 1;
`endif

  typedef struct {
    int          port;
    logic [31:0] result;
    logic        zero;
    logic        err;
    int          lat;
    int          pulses;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Device A: round-robin build
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_cmd, req1_cmd;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result;
  logic        alu_enable, alu_zero, busy;
  logic [4:0]  alu_command;
  logic [31:0] alu_data1, alu_data2, alu_result;

  // Device B: fixed-priority build
  logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [4:0]  b_req0_cmd, b_req1_cmd;
  logic [31:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
  logic        b_rsp0_valid, b_rsp0_ready, b_rsp0_zero, b_rsp0_err;
  logic        b_rsp1_valid, b_rsp1_ready, b_rsp1_zero, b_rsp1_err;
  logic [31:0] b_rsp0_result, b_rsp1_result;
  logic        b_alu_enable, b_alu_zero, b_busy;
  logic [4:0]  b_alu_command;
  logic [31:0] b_alu_data1, b_alu_data2, b_alu_result;

  alu_share_arbiter #(.DATA_W(32), .CMD_W(5), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .rsp1_err(rsp1_err),
    .alu_enable(alu_enable), .alu_command(alu_command), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  alu_share_arbiter #(.DATA_W(32), .CMD_W(5), .FIXED_PRIO(1)) u_dut_fixed (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_cmd(b_req0_cmd), .req0_a(b_req0_a),
    .req0_b(b_req0_b),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_result(b_rsp0_result), .rsp0_zero(b_rsp0_zero),
    .rsp0_err(b_rsp0_err),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_cmd(b_req1_cmd), .req1_a(b_req1_a),
    .req1_b(b_req1_b),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_result(b_rsp1_result), .rsp1_zero(b_rsp1_zero),
    .rsp1_err(b_rsp1_err),
    .alu_enable(b_alu_enable), .alu_command(b_alu_command), .alu_data1(b_alu_data1), .alu_data2(b_alu_data2),
    .alu_result(b_alu_result), .alu_zero(b_alu_zero), .busy(b_busy)
  );

  // Behavioural ALU: computes on the rising edge of its enable.
  function automatic logic [31:0] alu_f(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      C_SUB:   return a - b;
      C_ADD:   return a + b;
      C_SL:    return a << b;
      C_XOR:   return a ^ b;
      C_OR:    return a | b;
      C_AND:   return a & b;
      default: return 32'h1111_1111;
    endcase
  endfunction

  initial begin
    alu_result = '0;
    alu_zero = 1'b0;
    b_alu_result = '0;
    b_alu_zero = 1'b0;
  end

  always @(posedge alu_enable) begin
    alu_result = alu_f(alu_command, alu_data1, alu_data2);
    alu_zero   = (alu_result == 32'd0);
  end

  always @(posedge b_alu_enable) begin
    b_alu_result = alu_f(b_alu_command, b_alu_data1, b_alu_data2);
    b_alu_zero   = (b_alu_result == 32'd0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input int p, input logic [31:0] r, input logic z, input logic e,
                            input int lat, input int pulses);
    exp_t x;
    x.port = p; x.result = r; x.zero = z; x.err = e; x.lat = lat; x.pulses = pulses;
    sb_q.push_back(x);
  endtask

  // Called at posedge+1; holds the request until accepted and returns at posedge+1 after the accept edge.
  task automatic drive(input int p, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    if (p == 0) begin req0_valid = 1'b1; req0_cmd = c; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_cmd = c; req1_a = a; req1_b = b; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? req0_ready : req1_ready;
    end
    if (!got) check("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = !busy && !rsp0_valid && !rsp1_valid && (sb_q.size() == 0);
    end
    if (!idle) check("idle_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  // Monitor for device A
  int          cyc = 0;
  int          acc_cyc = 0;
  int          pulses = 0;
  logic        prev_v = 1'b0;
  logic        m_v, m_rdy, m_z, m_e, o_v;
  logic [31:0] m_res, o_res;
  exp_t        m_e_x;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      pulses = 0;
      prev_v = 1'b0;
    end else begin
      if (alu_enable) pulses++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc + 1;
      for (int p = 0; p < 2; p++) begin
        m_v   = (p == 0) ? rsp0_valid  : rsp1_valid;
        m_rdy = (p == 0) ? rsp0_ready  : rsp1_ready;
        m_res = (p == 0) ? rsp0_result : rsp1_result;
        m_z   = (p == 0) ? rsp0_zero   : rsp1_zero;
        m_e   = (p == 0) ? rsp0_err    : rsp1_err;
        o_v   = (p == 0) ? rsp1_valid  : rsp0_valid;
        o_res = (p == 0) ? rsp1_result : rsp0_result;
        if (m_v) begin
          if (sb_q.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            m_e_x = sb_q[0];
            check("rsp_port", 64'(p), 64'(m_e_x.port));
            check("rsp_result", 64'(m_res), 64'(m_e_x.result));
            check("rsp_zero", 64'(m_z), 64'(m_e_x.zero));
            check("rsp_err", 64'(m_e), 64'(m_e_x.err));
            if (!prev_v) check("rsp_latency", 64'(cyc - acc_cyc), 64'(m_e_x.lat));
            if (m_rdy) begin
              check("alu_pulses", 64'(pulses), 64'(m_e_x.pulses));
              check("nonowner_quiet", {31'd0, o_v, o_res}, 64'd0);
              void'(sb_q.pop_front());
              pulses = 0;
            end
          end
        end
      end
      prev_v = rsp0_valid | rsp1_valid;
    end
  end

  // Monitor for device B
  int b_acc0 = 0;
  int b_r1_seen = 0;
  int b_rsp1_seen = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (b_req0_valid && b_req0_ready) b_acc0++;
      if (b_req1_ready) b_r1_seen++;
      if (b_rsp1_valid) b_rsp1_seen++;
      if (b_rsp0_valid && b_rsp0_ready) check("fixed_prio_result", 64'(b_rsp0_result), 64'd3);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    req0_valid = 0; req0_cmd = 0; req0_a = 0; req0_b = 0; rsp0_ready = 1;
    req1_valid = 0; req1_cmd = 0; req1_a = 0; req1_b = 0; rsp1_ready = 1;
    b_req0_valid = 0; b_req0_cmd = C_ADD; b_req0_a = 32'd1; b_req0_b = 32'd2; b_rsp0_ready = 1;
    b_req1_valid = 0; b_req1_cmd = C_SUB; b_req1_a = 32'd7; b_req1_b = 32'd7; b_rsp1_ready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctrl", {22'd0, busy, alu_enable, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                         rsp0_zero, rsp1_zero, rsp0_err, rsp1_err, rsp1_result}, 64'd0);
    check("reset_alu_cmd_data1", {27'd0, alu_command, alu_data1}, 64'd0);
    check("reset_data2_rsp0", {alu_data2, rsp0_result}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: port 0 ADD 5+7
    expect_rsp(0, 32'd12, 1'b0, 1'b0, 3, 1);
    drive(0, C_ADD, 32'd5, 32'd7);
    wait_idle();

    // 2: port 1 SUB 9-9 with a stalled response
    rsp1_ready = 1'b0;
    expect_rsp(1, 32'd0, 1'b1, 1'b0, 3, 1);
    drive(1, C_SUB, 32'd9, 32'd9);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rsp1_valid;
    end
    if (!got) check("rsp1_wait_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("busy_during_stall", 64'(busy), 64'd1);
      check("rsp1_valid_held", 64'(rsp1_valid), 64'd1);
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    wait_idle();

    // 3: both ports contend; round-robin gives 0,1,0,1
    expect_rsp(0, 32'h0000_00FF, 1'b0, 1'b0, 3, 1);
    expect_rsp(1, 32'h0000_0010, 1'b0, 1'b0, 3, 1);
    expect_rsp(0, 32'h0000_0000, 1'b1, 1'b0, 3, 1);
    expect_rsp(1, 32'h0000_000F, 1'b0, 1'b0, 3, 1);
    fork
      begin
        drive(0, C_OR, 32'h0000_00F0, 32'h0000_000F);
        drive(0, C_XOR, 32'h0000_00FF, 32'h0000_00FF);
      end
      begin
        drive(1, C_SL, 32'd1, 32'd4);
        drive(1, C_AND, 32'h0000_00FF, 32'h0000_000F);
      end
    join
    wait_idle();

    // 6: illegal command on port 0 (leaves last grant = 0)
    expect_rsp(0, 32'h1111_1111, 1'b0, BAD_ERR, BAD_LAT, BAD_PULSES);
    drive(0, C_BAD, 32'd3, 32'd4);
    wait_idle();

    // 5: reset during FIRE abandons the transaction and restores port-0 priority
    drive(1, C_ADD, 32'd2, 32'd3);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = alu_enable;
    end
    if (!got) check("fire_wait_timeout", 64'd0, 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_ctrl", {60'd0, alu_enable, rsp0_valid, rsp1_valid, busy}, 64'd0);
    check("abort_alu_bus", {27'd0, alu_command, alu_data1}, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    expect_rsp(0, 32'hFFFF_FFFE, 1'b0, 1'b0, 3, 1);
    expect_rsp(1, 32'h0000_00FF, 1'b0, 1'b0, 3, 1);
    fork
      drive(0, C_SUB, 32'd3, 32'd5);
      drive(1, C_XOR, 32'h0000_00A5, 32'h0000_005A);
    join
    wait_idle();

    // 4: fixed priority build with both ports valid for 20 cycles
    b_req0_valid = 1'b1;
    b_req1_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    b_req0_valid = 1'b0;
    b_req1_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("fixed_prio_port0_grants", 64'(b_acc0), 64'd4);
    check("fixed_prio_req1_ready_never", 64'(b_r1_seen), 64'd0);
    check("fixed_prio_rsp1_never", 64'(b_rsp1_seen), 64'd0);
    check("fixed_prio_idle", {62'd0, b_busy, b_alu_enable}, 64'd0);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single event-triggered ALU between two requesters: port 0 is the main execute datapath, port 1 is the branch/compare unit.
- Arbitrates requests, latches operands, and sequences the ALU enable pulse. The ALU computes on a rising edge of its enable input.
- Captures the ALU result and zero flag, and returns them to the granted requester over a valid/ready response handshake.
- Sits between the control unit/execute stage and the ALU.

Parameters:
DATA_W, 32, operand and result width
CMD_W, 5, ALU command width (SUB=00001, ADD=00010, SL=00100, XOR=01000, OR=10000, AND=00111)
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = port 0 always wins

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle when valid&ready
req0_cmd  in  CMD_W  port 0 ALU command
req0_a  in  DATA_W  port 0 operand 1
req0_b  in  DATA_W  port 0 operand 2
rsp0_valid  out  1  port 0 response valid
rsp0_ready  in  1  port 0 response consumed
rsp0_result  out  DATA_W  port 0 result
rsp0_zero  out  1  port 0 zero flag
rsp0_err  out  1  port 0 illegal-command flag
req1_*, rsp1_*  (same set as port 0)  port 1 equivalents
alu_enable  out  1  ALU trigger; ALU computes on its rising edge
alu_command  out  CMD_W  command to ALU
alu_data1  out  DATA_W  operand 1 to ALU
alu_data2  out  DATA_W  operand 2 to ALU
alu_result  in  DATA_W  ALU result
alu_zero  in  1  ALU zero flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; all outputs 0.
  - alu_enable = 0; operand/command regs = 0.
  - Last-grant pointer = 1, so port 0 wins first.
  - Reset mid-transaction abandons it: no response issued, ALU outputs driven 0 immediately.
- States: IDLE -> SETUP -> FIRE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - Arbitration is combinational from the valid inputs. reqN_ready = (state==IDLE) && (grant==N). At most one ready is high.
  - Only one valid high: that port is granted.
  - Both valid: FIXED_PRIO=0 grants the port not equal to the last-grant pointer; FIXED_PRIO=1 grants port 0.
  - On an accept edge: latch cmd/a/b into alu_command/alu_data1/alu_data2, record owner, go to SETUP.
- SETUP: alu_enable = 0, operands stable for one full cycle -> FIRE.
- FIRE: alu_enable = 1 for exactly one cycle; this rising edge triggers the ALU -> CAPTURE.
- CAPTURE:
  - alu_enable = 0.
  - At the end of this cycle, register alu_result/alu_zero into the owner's rsp_result/rsp_zero -> RESP.
- RESP:
  - Owner's rsp_valid = 1; result/zero/err held stable until rsp_ready.
  - On the rsp_valid&rsp_ready edge: drop rsp_valid, update last-grant pointer = owner, go to IDLE.
- Latency: accept at edge k; rsp_valid high from cycle k+4. Minimum 5 cycles per operation, no overlap.
- Requests are never accepted outside IDLE. A response handshake and a new request valid in the same cycle do not interact; the new request is granted in the following IDLE cycle.
- A non-owner port's rsp_* stays 0.
- alu_command/alu_data* hold their last values after RESP until the next accept.
- Stability: a requester holding valid without ready must keep cmd/a/b stable. The block samples them only at the accept edge.
- Widths: no arithmetic inside the block; result and zero are passed through from the ALU unmodified.

Optional Feature:
- Macro: ALU_CMD_CHECK_EN.
- Defined:
  - At accept, a cmd not in {00001, 00010, 00100, 01000, 10000, 00111} skips SETUP/FIRE/CAPTURE and goes straight to RESP.
  - Response: rsp_result = 32'h11111111, rsp_zero = 0, rsp_err = 1. alu_enable is never pulsed.
- Not defined:
  - rsp_err is tied 0.
  - Illegal commands take the normal path, and the ALU default value 32'h11111111 is returned with zero = 0.

Test Plan:
1. Reset then port 0: ADD a=5, b=7 -> alu_enable pulses once in cycle k+2; rsp0_valid in cycle k+4 with result=12, zero=0.
2. Port 1: SUB a=9, b=9 with rsp1_ready held low 3 cycles -> rsp1_result=0, rsp1_zero=1 held stable; busy stays high until the handshake.
3. Both valid every cycle, FIXED_PRIO=0 -> grants alternate 0,1,0,1; each response goes only to its owner (e.g. port 0 OR 0xF0|0x0F=0xFF, port 1 SL 1<<4=0x10).
4. FIXED_PRIO=1, both valid continuously -> port 0 granted every time; req1_ready never high.
5. Assert reset_n low during FIRE -> alu_enable and rsp_valid go 0 immediately; after release, the first grant is port 0 and no stale response appears.
6. cmd=00011 -> with ALU_CMD_CHECK_EN: no alu_enable pulse, rsp_err=1, result 0x11111111 in cycle k+1. Without the macro: normal pulse, result 0x11111111, err=0.
